// File: rtl/module_1_clk_seq.sv
// module_1_clk_seq: glitch-free clk1 mux/gate sequencer with PLL-lock supervision.
// Outputs are registered from the next-state decode so they change on the same edge as the state.
module module_1_clk_seq #(
    parameter int GUARD_CYC   = 8,
    parameter int LOCK_STABLE = 16
) (
    input  logic clk_src,
    input  logic rst_n_sys,
    input  logic pll_locked,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_sel,
    input  logic req_clk1_en,
    input  logic req_clk3_en,
    output logic clk1_sel,
    output logic clk1_en,
    output logic clk3_en,
    output logic done,
    output logic lock_err
);
    typedef enum logic [2:0] {WAIT_LOCK, IDLE, GATE_OFF, SWITCH, GATE_ON} state_t;
    localparam logic [7:0] GUARD_TC = 8'(GUARD_CYC - 1);
    localparam logic [7:0] LOCK_TC  = 8'(LOCK_STABLE - 1);
    state_t     state, state_d;
    logic       lk_m, lk_s;
    logic [7:0] lock_cnt, gcnt;
    logic       cap_sel, cap_en1, cap_en3;
    logic       sel_d, en1_d, en3_d, done_d, err_d;
    logic       accept, lock_lost, guard_tc;
    assign accept    = req_valid && state == IDLE && lk_s;
    assign lock_lost = state != WAIT_LOCK && !lk_s;
    assign guard_tc  = gcnt == GUARD_TC;
    always_comb begin
        state_d = state;
        sel_d   = clk1_sel;
        en1_d   = clk1_en;
        en3_d   = clk3_en;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            WAIT_LOCK: state_d = (lk_s && lock_cnt == LOCK_TC) ? IDLE : WAIT_LOCK;
            IDLE: begin
                if (accept && req_sel == clk1_sel) begin
                    en1_d  = req_clk1_en;
                    en3_d  = req_clk3_en;
                    done_d = 1'b1;
                end else if (accept) begin
                    state_d = GATE_OFF;
                    en1_d   = 1'b0;
                end
            end
            GATE_OFF: begin
                en1_d   = 1'b0;
                state_d = guard_tc ? SWITCH : GATE_OFF;
                sel_d   = guard_tc ? cap_sel : clk1_sel;
            end
            SWITCH: begin
                state_d = guard_tc ? GATE_ON : SWITCH;
                en1_d   = guard_tc ? cap_en1 : 1'b0;
                en3_d   = guard_tc ? cap_en3 : clk3_en;
                done_d  = guard_tc;
            end
            GATE_ON: state_d = IDLE;
            default: state_d = WAIT_LOCK;
        endcase
        // Lock loss overrides everything, including a coincident accept.
        if (lock_lost) begin
            state_d = WAIT_LOCK;
            sel_d   = clk1_sel;
            en1_d   = 1'b0;
            en3_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
    end
    always_ff @(posedge clk_src or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            lk_m      <= 1'b0;
            lk_s      <= 1'b0;
            state     <= WAIT_LOCK;
            lock_cnt  <= 8'd0;
            gcnt      <= 8'd0;
            cap_sel   <= 1'b0;
            cap_en1   <= 1'b0;
            cap_en3   <= 1'b0;
            clk1_sel  <= 1'b0;
            clk1_en   <= 1'b0;
            clk3_en   <= 1'b0;
            req_ready <= 1'b0;
            done      <= 1'b0;
            lock_err  <= 1'b0;
        end else begin
            lk_m      <= pll_locked;
            lk_s      <= lk_m;
            state     <= state_d;
            lock_cnt  <= (state == WAIT_LOCK && state_d == WAIT_LOCK && lk_s) ? lock_cnt + 8'd1 : 8'd0;
            gcnt      <= (state_d != state) ? 8'd0 : guard_tc ? gcnt : gcnt + 8'd1;
            cap_sel   <= accept ? req_sel : cap_sel;
            cap_en1   <= accept ? req_clk1_en : cap_en1;
            cap_en3   <= accept ? req_clk3_en : cap_en3;
            clk1_sel  <= sel_d;
            clk1_en   <= en1_d;
            clk3_en   <= en3_d;
            req_ready <= state_d == IDLE;
            done      <= done_d;
            lock_err  <= err_d;
        end
    end
endmodule

// File: tb/tb_module_1_clk_seq.sv
// tb_module_1_clk_seq: directed checks of lock qualification, fast/switch paths, lock loss and reset abort.
module tb_module_1_clk_seq;
    logic clk_src = 1'b0;
    logic rst_n_sys, pll_locked, req_valid, req_sel, req_clk1_en, req_clk3_en;
    logic req_ready, clk1_sel, clk1_en, clk3_en, done, lock_err;
    int   vectors = 0;
    int   miscompares = 0;
    always #5 clk_src = ~clk_src;
    module_1_clk_seq #(.GUARD_CYC(8), .LOCK_STABLE(16)) dut (
        .clk_src(clk_src), .rst_n_sys(rst_n_sys), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_clk1_en(req_clk1_en), .req_clk3_en(req_clk3_en),
        .clk1_sel(clk1_sel), .clk1_en(clk1_en), .clk3_en(clk3_en),
        .done(done), .lock_err(lock_err)
    );
    // Expected vector order: {clk1_sel, clk1_en, clk3_en, req_ready, done, lock_err}
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {clk1_sel, clk1_en, clk3_en, req_ready, done, lock_err};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk_src);
        #1;
    endtask
    task automatic drive(input logic v, input logic s, input logic e1, input logic e3);
        req_valid   = v;
        req_sel     = s;
        req_clk1_en = e1;
        req_clk3_en = e3;
    endtask
    // Lock seen at the pin just before the first edge: lk_s high after edge 2, IDLE at edge 18.
    task automatic wait_lock(input string tag, input logic sel);
        for (int k = 1; k <= 18; k++) begin
            step();
            chk(tag, {sel, 1'b0, 1'b0, k == 18, 1'b0, 1'b0});
        end
    endtask
    initial begin
        rst_n_sys  = 1'b0;
        pll_locked = 1'b1;
        drive(0, 0, 0, 0);
        repeat (3) step();
        chk("reset", 6'b000000);
        rst_n_sys = 1'b1;
        wait_lock("boot", 1'b0);
        drive(1, 0, 1, 1);
        step();
        chk("fast", 6'b011110);
        drive(0, 0, 0, 0);
        step();
        chk("fast_hold", 6'b011100);
        drive(1, 1, 1, 0);
        for (int n = 1; n <= 18; n++) begin
            step();
            drive(0, 0, 0, 0);
            chk("switch", {n >= 9, n >= 17, n < 17, n >= 18, n == 17, 1'b0});
        end
        drive(1, 0, 1, 1);
        for (int n = 1; n <= 11; n++) begin
            step();
            drive(0, 0, 0, 0);
            chk("sw_pre_loss", {n < 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        pll_locked = 1'b0;
        step();
        chk("loss_sync1", 6'b000000);
        step();
        chk("loss_sync2", 6'b000000);
        step();
        chk("lock_err", 6'b000001);
        step();
        chk("lock_err_end", 6'b000000);
        pll_locked = 1'b1;
        wait_lock("relock", 1'b0);
        pll_locked = 1'b0;
        step();
        chk("idle_loss1", 6'b000100);
        step();
        chk("idle_loss2", 6'b000100);
        drive(1, 0, 1, 1);
        step();
        chk("loss_vs_accept", 6'b000001);
        drive(0, 0, 0, 0);
        step();
        chk("loss_vs_accept2", 6'b000000);
        pll_locked = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            chk("glitch", {1'b0, 1'b0, 1'b0, k == 31, 1'b0, 1'b0});
            if (k == 12) pll_locked = 1'b0;
            if (k == 13) pll_locked = 1'b1;
        end
        drive(1, 0, 1, 1);
        step();
        chk("fast2", 6'b011110);
        drive(1, 1, 1, 1);
        step();
        chk("b2b_gate_off", 6'b001000);
        drive(0, 0, 0, 0);
        step();
        step();
        chk("gate_off", 6'b001000);
        #2;
        rst_n_sys = 1'b0;
        #1;
        chk("async_rst", 6'b000000);
        repeat (2) step();
        chk("in_rst", 6'b000000);
        rst_n_sys = 1'b1;
        wait_lock("rst_relock", 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
